uart_phy_lite: RTL and testbench

- Serial 8N1 UART line PHY at the far end of the memory-mapped UART lite's tx/rx handshake.
- Serialises bytes offered on tx_data/tx_valid onto txd.
- Deserialises rxd into single-cycle rx_data/rx_ready strobes.
- Sits between the SRAM-mapped UART register block and the board pins; one clock domain, rxd is asynchronous.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_bit_timer.sv | 45 ++++
 rtl/uart_phy_lite.sv | 211 +++++++++++++++++++++
 tb/tb_uart_phy_lite.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the serial UART line PHY.
//   DATA_BITS  - payload bits per 8N1 frame
//   tx_state_e - transmit FSM states
//   rx_state_e - receive FSM states
//   bit_cnt_w  - width of a bit timer counting 0..clks_per_bit-1
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Literals carry a TX_/RX_ prefix so both enums can share one package scope.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  function automatic int bit_cnt_w(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter, 0..CLKS_PER_BIT-1, wrapping
// to 0 at the terminal count.
//   clka - system clock
//   rstn - synchronous active-low reset
//   clr  - synchronous clear to 0 (wins over wrap/increment)
//   tick - high while the count is at CLKS_PER_BIT-1 (end of a bit)
//   mid  - high while the count is at CLKS_PER_BIT/2-1 (middle of a bit)
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clka,
  input  logic rstn,
  input  logic clr,
  output logic tick,
  output logic mid
);

  localparam int CNT_W = bit_cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == TERM_CNT);
  assign mid  = (cnt_q == HALF_CNT);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clka) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_phy_lite.sv
// uart_phy_lite: 8N1 serial line PHY between the UART register block and pins.
//   clka         - system clock
//   rstn         - synchronous active-low reset
//   tx_data      - byte to send, qualified by tx_valid
//   tx_valid     - single-cycle send request
//   tx_ready     - transmitter idle, next tx_valid will be accepted
//   tx_drop      - one-cycle pulse: tx_valid seen while busy, byte discarded
//   txd          - registered serial output, idle high
//   rxd          - asynchronous serial input
//   rx_data      - last good received byte, held until the next good frame
//   rx_ready     - one-cycle pulse: rx_data newly valid
//   rx_frame_err - one-cycle pulse: stop bit sampled low
module uart_phy_lite
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clka,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_drop,
  output logic       txd,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_frame_err
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic       txd_q, txd_d;
  logic       tx_drop_q, tx_drop_d;
  logic       tx_clr, tx_tick, tx_mid_unused;

  rx_state_e              rx_state_q, rx_state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [2:0]             rx_idx_q, rx_idx_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   rx_err_q, rx_err_d;
  logic                   rx_clr, rx_tick, rx_mid;
  logic                   rxd_s;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clka (clka),
    .rstn (rstn),
    .clr  (tx_clr),
    .tick (tx_tick),
    .mid  (tx_mid_unused)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clka (clka),
    .rstn (rstn),
    .clr  (rx_clr),
    .tick (rx_tick),
    .mid  (rx_mid)
  );

  assign tx_ready     = (tx_state_q == TX_IDLE);
  assign tx_drop      = tx_drop_q;
  assign txd          = txd_q;
  assign rx_data      = rx_data_q;
  assign rx_ready     = rx_ready_q;
  assign rx_frame_err = rx_err_q;
  assign rxd_s        = sync_q[SYNC_STAGES-1];

  // Transmit: the timer is held at 0 in IDLE so START gets a full bit period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    txd_d      = txd_q;
    tx_drop_d  = tx_valid && (tx_state_q != TX_IDLE);
    tx_clr     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_clr = 1'b1;
        txd_d  = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_idx_q == LAST_BIT) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_idx_d   = tx_idx_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Receive: the timer restarts at the middle of the start bit, so every
  // later terminal tick lands in the middle of a data or stop bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_idx_d   = rx_idx_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = 1'b0;
    rx_err_d   = 1'b0;
    rx_clr     = 1'b0;
    sync_d     = {sync_q[SYNC_STAGES-2:0], rxd};
    case (rx_state_q)
      RX_IDLE: begin
        rx_clr = 1'b1;
        if (!rxd_s) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_mid) begin
          rx_clr     = 1'b1;
          rx_idx_d   = '0;
          rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          if (rx_idx_q == LAST_BIT) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          if (rxd_s) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_err_d   = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rxd_s) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Control state and visible outputs.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      txd_q      <= 1'b1;
      tx_drop_q  <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_idx_q   <= '0;
      sync_q     <= '1;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      txd_q      <= txd_d;
      tx_drop_q  <= tx_drop_d;
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      sync_q     <= sync_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Shift registers are always reloaded before use and need no reset.
  always_ff @(posedge clka) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

endmodule

// File: tb/tb_uart_phy_lite.sv
module tb_uart_phy_lite;

  localparam int CPB = 8;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clka = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_drop, txd;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_ready, rx_frame_err;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_phy_lite #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clka         (clka),
    .rstn         (rstn),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_drop      (tx_drop),
    .txd          (txd),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  // Issue one tx_valid pulse and follow the whole frame cycle by cycle.
  task automatic tx_frame(input logic [7:0] d, input bit busy);
    logic [9:0] bits;
    int bad;
    int i;
    bits = {1'b1, d, 1'b0};
    tx_data = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        i = b * CPB + c;
        if (txd !== bits[b] || tx_ready !== 1'b0) bad++;
        if (busy && i == 20) begin
          tx_data = 8'hFF;
          tx_valid = 1'b1;
        end
        if (i == 21) begin
          tx_valid = 1'b0;
          check("tx_drop_pulse", {31'd0, tx_drop}, {31'd0, busy});
        end
        if (i == 22) check("tx_drop_clear", {31'd0, tx_drop}, 32'd0);
        step(1);
      end
      check($sformatf("txd_bit%0d_of_%02h", b, d), bad, 0);
    end
    check("tx_ready_after_frame", {31'd0, tx_ready}, 32'd1);
    check("txd_idle_after_frame", {31'd0, txd}, 32'd1);
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rxd_drv = bits[b];
      step(CPB);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic push_exp(input bit err, input logic [7:0] d, input int c);
    exp_t e;
    e.err = err;
    e.data = d;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Receive-side monitor: every strobe must match the next queued expectation.
  always @(negedge clka) begin
    if (rx_ready === 1'b1 || rx_frame_err === 1'b1) begin
      if (rx_ready === 1'b1 && rx_frame_err === 1'b1) begin
        check("rx_strobes_exclusive", 32'd3, 32'd1);
      end else if (exp_q.size() == 0) begin
        check("rx_unexpected_strobe", {30'd0, rx_frame_err, rx_ready}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_strobe_kind", {31'd0, rx_frame_err}, {31'd0, mon_e.err});
        if (!mon_e.err) check("rx_data_on_ready", {24'd0, rx_data}, {24'd0, mon_e.data});
        if (mon_e.cyc >= 0) check("rx_ready_latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    // Reset with the line idle.
    rstn = 1'b0;
    step(3);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_tx_drop", {31'd0, tx_drop}, 32'd0);
    check("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    rstn = 1'b1;
    step(2);

    // Plain frame, then the same frame with a request arriving while busy.
    tx_frame(8'h55, 1'b0);
    step(5);
    tx_frame(8'h55, 1'b1);
    step(5);

    // Loopback: rx_ready 79 cycles after txd falls (txd falls at the accept edge).
    loop_en = 1'b1;
    push_exp(1'b0, 8'hA3, cyc + 1 + 79);
    tx_frame(8'hA3, 1'b0);
    step(10);
    loop_en = 1'b0;
    step(5);
    check("loopback_rx_data_held", {24'd0, rx_data}, 32'h0000_00A3);

    // Short glitch must be rejected, then a clean frame accepted.
    rxd_drv = 1'b0;
    step(2);
    rxd_drv = 1'b1;
    step(30);
    push_exp(1'b0, 8'h3C, -1);
    rx_frame(8'h3C, 1'b1);
    step(16);
    check("rx_data_3c", {24'd0, rx_data}, 32'h0000_003C);

    // Framing error with the line held low afterwards.
    push_exp(1'b1, 8'h00, -1);
    rx_frame(8'h0F, 1'b0);
    rxd_drv = 1'b0;
    step(20);
    rxd_drv = 1'b1;
    step(16);
    check("rx_data_after_frame_err", {24'd0, rx_data}, 32'h0000_003C);
    push_exp(1'b0, 8'h81, -1);
    rx_frame(8'h81, 1'b1);
    step(16);
    check("rx_data_81", {24'd0, rx_data}, 32'h0000_0081);

    // Reset in the middle of an incoming frame: no strobe may follow.
    rxd_drv = 1'b0;
    step(CPB);
    rxd_drv = 1'b1;
    step(CPB);
    rxd_drv = 1'b0;
    step(CPB);
    rstn = 1'b0;
    rxd_drv = 1'b1;
    step(3);
    check("midframe_reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("midframe_reset_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("midframe_reset_txd", {31'd0, txd}, 32'd1);
    rstn = 1'b1;
    step(120);
    check("rx_data_idle_after_reset", {24'd0, rx_data}, 32'd0);

    check("rx_expected_strobes_outstanding", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
